// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// transmit-arbiter FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between byte producers, the transmit arbiter and the uart_tx instance.
// master = arbiter side, slave = producers plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  import uart_pkg::*;

  // Handshake: req[i] is a level held with data_in lane i stable until gnt[i]
  // pulses for one cycle; the byte is accepted on that pulse. tx_start is a
  // one-cycle pulse qualifying tx_data; tx_busy reports the transmitter state.
  logic [N_REQ-1:0]             req;
  logic [N_REQ*UART_DATA_W-1:0] data_in;
  logic [N_REQ-1:0]             gnt;
  logic                         tx_start;
  logic [UART_DATA_W-1:0]       tx_data;
  logic                         tx_busy;
  logic                         active;
  logic [ID_W-1:0]              cur_id;

  modport master (
    input  req, data_in, tx_busy,
    output gnt, tx_start, tx_data, active, cur_id
  );

  modport slave (
    output req, data_in, tx_busy,
    input  gnt, tx_start, tx_data, active, cur_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin picker; scans req starting at ptr,
// wrapping modulo N_REQ, and returns the first pending index.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [ID_W-1:0]  win_id,
  output logic             any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  always_comb begin
    win_oh = '0;
    win_id = '0;
    any    = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ptr < N_REQ and i < N_REQ, so one conditional subtract wraps the sum
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      cand = sum[ID_W-1:0];
      if (!any && req[cand]) begin
        any          = 1'b1;
        win_oh[cand] = 1'b1;
        win_id       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte producers, one byte in
// flight at a time. Define UART_TX_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus,
  output arb_state_t        dbg_state
);

  arb_state_t             state;
  logic [N_REQ-1:0]       gnt_q;
  logic                   tx_start_q;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic [UART_DATA_W-1:0] win_data;
  logic [ID_W-1:0]        cur_id_q;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        win_id;
  logic [N_REQ-1:0]       win_oh;
  logic                   win_any;
  logic                   take;

  rr_select #(.N_REQ(N_REQ), .ID_W(ID_W)) u_sel (
    .req    (bus.req),
    .ptr    (ptr),
    .win_oh (win_oh),
    .win_id (win_id),
    .any    (win_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_oh[i]) win_data = bus.data_in[i*UART_DATA_W +: UART_DATA_W];
  end

  // A grant needs an idle arbiter and an idle transmitter, even a foreign busy.
  assign take = (state == ARB_IDLE) && !bus.tx_busy && win_any;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (take) ptr <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cur_id_q   <= '0;
    end else begin
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (take) begin
            gnt_q     <= win_oh;
            tx_data_q <= win_data;
            cur_id_q  <= win_id;
            state     <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          tx_start_q <= 1'b1;
          state      <= ARB_WAIT_BUSY;
        end
        // uart_tx raises busy a cycle after start; wait for it before watching for done
        ARB_WAIT_BUSY: if (bus.tx_busy)  state <= ARB_WAIT_DONE;
        ARB_WAIT_DONE: if (!bus.tx_busy) state <= ARB_IDLE;
        default:                         state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.cur_id   = cur_id_q;
  assign bus.active   = (state != ARB_IDLE);
  assign dbg_state    = state;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` byte transmitter between `N_REQ` independent requesters. Selects one pending byte with round-robin arbitration and drives the transmitter's `start`/`data_in`. Tracks the transmitter's `busy` so that exactly one byte is in flight at a time. Sits between the byte producers (debug print, status reporter, loopback) and the single `uart_tx` instance driving the pin.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8
- `ID_W`, `$clog2(N_REQ)`: width of requester index

Ports:
- `clk` in 1: system clock; only clock in the block
- `rst` in 1: reset, synchronous, active-high
- `req` in `N_REQ`: per-requester "byte pending"; level, held until granted
- `data_in` in `N_REQ*8`: byte for requester i at `[8*i+7:8*i]`; stable while `req[i]` high
- `gnt` out `N_REQ`: one-hot, one-cycle pulse; byte i accepted; requester may drop or change `req`/data next cycle
- `tx_start` out 1: to `uart_tx.start`; one-cycle pulse
- `tx_data` out 8: to `uart_tx.data_in`; registered, valid when `tx_start` high
- `tx_busy` in 1: from `uart_tx.busy`
- `active` out 1: high from grant until transmitter returns idle
- `cur_id` out `ID_W`: index of last granted requester

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE**:
  - If `tx_busy`=0 and `|req`, pick the winner w and pulse `gnt[w]`.
  - In the same edge, latch `tx_data` from w's lane and set `cur_id`=w.
  - Go to LAUNCH.
  - If `tx_busy`=1 (foreign or leftover transmission), stay and grant nothing.
- **LAUNCH**: `tx_start`=1 for this single cycle, then WAIT_BUSY.
- **WAIT_BUSY**: stay until `tx_busy`=1, then WAIT_DONE. This covers the transmitter's one-cycle-late busy.
- **WAIT_DONE**: stay while `tx_busy`=1; on `tx_busy`=0 go to IDLE.
- **Round-robin**:
  - Pointer p starts at 0.
  - Search order is p, p+1, …, wrapping modulo `N_REQ`.
  - After granting w, p becomes (w+1) mod `N_REQ`. When w=`N_REQ`-1, p wraps to 0.
- `active` = (state != IDLE).
- `req` changes outside IDLE are ignored until the next IDLE evaluation.
- A requester re-raising `req` immediately after its grant waits behind all other pending requesters.

## Timing
- Reset values: `gnt`=0, `tx_start`=0, `tx_data`=8'h00, `active`=0, `cur_id`=0, p=0, state IDLE.
- Grant latency: `req` seen high at edge k (IDLE, `tx_busy`=0) → `gnt` high in cycle k+1 → `tx_start` high in cycle k+2.
- Back-to-back bytes:
  - The next grant occurs in the first IDLE cycle after `tx_busy` falls.
  - Minimum gap: 1 cycle after `tx_busy` low.
- Simultaneous requests: exactly one grant per byte; never two bits of `gnt` set.
- Reset mid-operation:
  - The arbiter returns to IDLE next edge; no `gnt`/`tx_start` in that cycle.
  - If `uart_tx` is still busy, the arbiter waits in IDLE for `tx_busy`=0 before granting.
- `tx_data` holds its value until the next grant.

## Configuration
- Macro: `UART_TX_ARB_FIXED_PRIO_EN`.
- **Defined**: fixed priority; the lowest index wins; pointer p is not implemented (tied to 0).
- **Undefined (default)**: round-robin as described above.
- The interface is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (`arb_state_t`, 2 bits)
  - `UART_DATA_W`=8
- Sub-module `rr_select`:
  - combinational round-robin picker
  - inputs: `req`, pointer
  - outputs: one-hot winner, winner index, any-valid
  - the fixed-priority build also uses it, with the pointer tied to 0
- The FSM, data mux/latch and pointer register live in `uart_tx_arbiter`.

## Test plan
- **Single requester**: `req`=4'b0100, lane2=8'hA5.
  - Expect `gnt`=4'b0100 one cycle, `tx_start` the next cycle with `tx_data`=8'hA5.
  - `active` stays high until `tx_busy` falls.
- **All requesting continuously**: `req`=4'b1111 with distinct bytes 8'h10..8'h13.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly one `tx_start` per completed transmission and the serial bytes in the same order.
- **Wrap**: after granting index 3, `req`=4'b1001 → next grant is index 0, then index 3.
- **Busy gating**: hold `tx_busy`=1 from outside with `req`=4'b0010 → no `gnt` until `tx_busy`=0, then grant within 1 cycle.
- **Reset mid-transfer**: assert `rst` during WAIT_DONE.
  - All outputs return to reset values the next cycle.
  - A pending `req` is granted only after `tx_busy`=0.
- **Fixed priority** (`UART_TX_ARB_FIXED_PRIO_EN` defined): `req`=4'b1011 held → index 0 granted repeatedly; index 3 never granted while bit 0 stays high.
